// File: rtl/etapa_ejecucion_pkg.sv
// etapa_ejecucion_pkg: opcodes, FSM state encoding and default data width for the execution stage
package etapa_ejecucion_pkg;
  localparam int ANCHO_DEF = 16;
  localparam logic [2:0] OP_SUMA  = 3'd0;
  localparam logic [2:0] OP_RESTA = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SHL   = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_MULT  = 3'd7;
  localparam logic [1:0] REPOSO    = 2'd0;
  localparam logic [1:0] LECTURA   = 2'd1;
  localparam logic [1:0] CALCULO   = 2'd2;
  localparam logic [1:0] ESCRITURA = 2'd3;
endpackage

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: unsigned shift-add multiplier (clk, rst, start, a, b -> done pulse, producto), first bit folded into the start edge
module multiplicador_secuencial
  import etapa_ejecucion_pkg::*;
#(
  parameter int ANCHO  = ANCHO_DEF,
  parameter int CICLOS = ANCHO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ANCHO-1:0]     a,
  input  logic [ANCHO-1:0]     b,
  output logic                 done,
  output logic [2*ANCHO-1:0]   producto
);
  localparam int CW = $clog2(CICLOS);
  logic [2*ANCHO-1:0] mcand;
  logic [ANCHO-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      producto <= '0;
    end else if (start) begin
      mcand    <= {{ANCHO{1'b0}}, a} << 1;
      mplier   <= b >> 1;
      producto <= b[0] ? {{ANCHO{1'b0}}, a} : '0;
      cnt      <= CW'(1);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= busy && cnt == CW'(CICLOS - 1);
      if (busy) begin
        producto <= producto + (mplier[0] ? mcand : '0);
        mcand    <= mcand << 1;
        mplier   <= mplier >> 1;
        cnt      <= cnt + CW'(1);
        busy     <= cnt != CW'(CICLOS - 1);
      end
    end
  end
endmodule

// File: rtl/etapa_ejecucion.sv
// etapa_ejecucion: read-compute-writeback stage for the 8x16 register bank (bank read addrs/data in, write port and flags out)
module etapa_ejecucion
  import etapa_ejecucion_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int CICLOS_MULT = ANCHO
) (
  input  logic             Reloj,
  input  logic             Reiniciar,
  input  logic             Inicio,
  input  logic [2:0]       Operacion,
  input  logic [2:0]       DirFuenteA,
  input  logic [2:0]       DirFuenteB,
  input  logic [2:0]       DirDestino,
  input  logic [ANCHO-1:0] RtaA,
  input  logic [ANCHO-1:0] RtaB,
  output logic [2:0]       DireccionA,
  output logic [2:0]       DireccionB,
  output logic [ANCHO-1:0] Tupla,
  output logic [2:0]       DireccionEscritura,
  output logic             Habilitar,
  output logic             Ocupado,
  output logic             Listo,
  output logic             Acarreo,
  output logic             Cero
);
  localparam int SW = $clog2(ANCHO);
  logic [1:0]         estado;
  logic [2:0]         op;
  logic [ANCHO-1:0]   opa, opb, alu_r;
  logic [ANCHO:0]     suma, resta;
  logic               alu_c, acarreo_pend, mult_done;
  logic [2*ANCHO-1:0] producto;
  assign Ocupado   = estado != REPOSO;
  assign Habilitar = estado == ESCRITURA;
  assign Listo     = estado == ESCRITURA;
  assign suma  = {1'b0, opa} + {1'b0, opb};
  assign resta = {1'b0, opa} - {1'b0, opb};
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (op)
      OP_SUMA:  {alu_c, alu_r} = suma;
      OP_RESTA: {alu_c, alu_r} = resta;
      OP_AND:   alu_r = opa & opb;
      OP_OR:    alu_r = opa | opb;
      OP_XOR:   alu_r = opa ^ opb;
      OP_SHL:   alu_r = opa << opb[SW-1:0];
      OP_SHR:   alu_r = opa >> opb[SW-1:0];
      default:  alu_r = '0;
    endcase
  end
  // The multiplier loads straight from the bank on the LECTURA->CALCULO edge so its
  // 16 iterations fill exactly the 16 CALCULO cycles.
  multiplicador_secuencial #(.ANCHO(ANCHO), .CICLOS(CICLOS_MULT)) u_mult (
    .clk      (Reloj),
    .rst      (Reiniciar),
    .start    (estado == LECTURA && op == OP_MULT),
    .a        (RtaA),
    .b        (RtaB),
    .done     (mult_done),
    .producto (producto)
  );
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      estado             <= REPOSO;
      op                 <= '0;
      DireccionA         <= '0;
      DireccionB         <= '0;
      DireccionEscritura <= '0;
      opa                <= '0;
      opb                <= '0;
      Tupla              <= '0;
      acarreo_pend       <= 1'b0;
      Acarreo            <= 1'b0;
      Cero               <= 1'b0;
    end else begin
      case (estado)
        REPOSO: if (Inicio) begin
          op                 <= Operacion;
          DireccionA         <= DirFuenteA;
          DireccionB         <= DirFuenteB;
          DireccionEscritura <= DirDestino;
          estado             <= LECTURA;
        end
        LECTURA: begin
          opa    <= RtaA;
          opb    <= RtaB;
          estado <= CALCULO;
        end
        CALCULO: if (op != OP_MULT || mult_done) begin
          Tupla        <= op == OP_MULT ? producto[ANCHO-1:0] : alu_r;
          acarreo_pend <= op == OP_MULT ? |producto[2*ANCHO-1:ANCHO] : alu_c;
          estado       <= ESCRITURA;
        end
        ESCRITURA: begin
          Acarreo <= acarreo_pend;
          Cero    <= Tupla == '0;
          estado  <= REPOSO;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_etapa_ejecucion.sv
// tb_etapa_ejecucion: scoreboard bench with a behavioural register bank and arithmetic reference model
module tb_etapa_ejecucion;
  logic        Reloj = 1'b0;
  logic        Reiniciar, Inicio;
  logic [2:0]  Operacion, DirFuenteA, DirFuenteB, DirDestino;
  logic [15:0] RtaA, RtaB, Tupla;
  logic [2:0]  DireccionA, DireccionB, DireccionEscritura;
  logic        Habilitar, Ocupado, Listo, Acarreo, Cero;
  typedef struct {
    logic [15:0] res;
    logic [2:0]  d;
    logic        c;
    logic        z;
    int          e0;
    int          lat;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] banco[8];
  logic [15:0] ref_regs[8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  int          cyc = 0, chk = 0, err = 0, escrituras = 0;
  logic        flag_pend = 1'b0, fe_c = 1'b0, fe_z = 1'b0;
  etapa_ejecucion dut (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Inicio(Inicio), .Operacion(Operacion),
    .DirFuenteA(DirFuenteA), .DirFuenteB(DirFuenteB), .DirDestino(DirDestino),
    .RtaA(RtaA), .RtaB(RtaB), .DireccionA(DireccionA), .DireccionB(DireccionB),
    .Tupla(Tupla), .DireccionEscritura(DireccionEscritura), .Habilitar(Habilitar),
    .Ocupado(Ocupado), .Listo(Listo), .Acarreo(Acarreo), .Cero(Cero)
  );
  always #5 Reloj = ~Reloj;
  assign RtaA = banco[DireccionA];
  assign RtaB = banco[DireccionB];
  always @(posedge Reloj) begin
    cyc <= cyc + 1;
    if (pre_en) banco[pre_a] <= pre_d;
    else if (Habilitar) banco[DireccionEscritura] <= Tupla;
  end
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%h expected=%h", n, got, exp);
    end
  endtask
  function automatic exp_t modelo(input logic [2:0] op, input int unsigned a, input int unsigned b, input logic [2:0] d);
    exp_t e;
    int unsigned r, p;
    e.c = 1'b0;
    case (op)
      3'd0: begin r = a + b; e.c = r > 32'hFFFF; end
      3'd1: begin r = a - b; e.c = a < b; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << (b % 16);
      3'd6: r = a >> (b % 16);
      default: begin p = a * b; r = p; e.c = (p >> 16) != 0; end
    endcase
    e.res = r[15:0];
    e.z   = e.res == 16'h0000;
    e.d   = d;
    e.lat = op == 3'd7 ? 17 : 2;
    e.e0  = 0;
    return e;
  endfunction
  always @(negedge Reloj) begin
    exp_t e;
    if (flag_pend) begin
      check("acarreo", Acarreo, fe_c);
      check("cero", Cero, fe_z);
      check("habilitar_ancho", Habilitar, 0);
      flag_pend = 1'b0;
    end
    if (Habilitar || Listo) begin
      escrituras++;
      if (sb.size() == 0) check("escritura_inesperada", Habilitar, 0);
      else begin
        e = sb.pop_front();
        check("tupla", Tupla, e.res);
        check("dir_escritura", DireccionEscritura, e.d);
        check("habilitar", Habilitar, 1);
        check("listo", Listo, 1);
        check("ocupado_escritura", Ocupado, 1);
        check("latencia", cyc - e.e0, e.lat);
        ref_regs[e.d] = e.res;
        fe_c = e.c;
        fe_z = e.z;
        flag_pend = 1'b1;
      end
    end
  end
  task automatic precarga(input logic [2:0] a, input logic [15:0] v);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = v;
    @(negedge Reloj);
    pre_en = 1'b0;
    ref_regs[a] = v;
  endtask
  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input int hold);
    exp_t e;
    e = modelo(op, ref_regs[a], ref_regs[b], d);
    e.e0 = cyc + 1;
    sb.push_back(e);
    Operacion  = op;
    DirFuenteA = a;
    DirFuenteB = b;
    DirDestino = d;
    Inicio     = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge Reloj);
      if (hold > 1) check("ocupado_continuo", Ocupado, 1);
    end
    Inicio = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge Reloj);
      n++;
    end while ((Ocupado || sb.size() != 0 || flag_pend) && n < 60);
    if (n >= 60) begin
      check("timeout_ocupado", Ocupado, 0);
      check("timeout_cola", sb.size(), 0);
    end
  endtask
  task automatic check_ceros(input string n);
    check({n, "_dira"}, DireccionA, 0);
    check({n, "_dirb"}, DireccionB, 0);
    check({n, "_tupla"}, Tupla, 0);
    check({n, "_dirw"}, DireccionEscritura, 0);
    check({n, "_hab"}, Habilitar, 0);
    check({n, "_ocupado"}, Ocupado, 0);
    check({n, "_listo"}, Listo, 0);
    check({n, "_acarreo"}, Acarreo, 0);
    check({n, "_cero"}, Cero, 0);
  endtask
  initial begin
    int w0;
    logic [15:0] v;
    Reiniciar = 1'b1;
    Inicio = 1'b0;
    Operacion = '0;
    DirFuenteA = '0;
    DirFuenteB = '0;
    DirDestino = '0;
    repeat (3) @(negedge Reloj);
    check_ceros("reset");
    Reiniciar = 1'b0;
    for (int i = 0; i < 8; i++) precarga(3'(i), 16'($urandom));
    precarga(3'd1, 16'h0003);
    precarga(3'd2, 16'h0004);
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1);
    wait_idle();
    check("suma_banco", banco[3], 16'h0007);
    check("suma_cero", Cero, 0);
    check("suma_acarreo", Acarreo, 0);
    issue(3'd1, 3'd1, 3'd2, 3'd4, 1);
    wait_idle();
    check("resta_banco", banco[4], 16'hFFFF);
    check("resta_borrow", Acarreo, 1);
    precarga(3'd1, 16'h1234);
    precarga(3'd2, 16'h1234);
    issue(3'd1, 3'd1, 3'd2, 3'd4, 1);
    wait_idle();
    check("resta_cero", Cero, 1);
    precarga(3'd1, 16'h0100);
    precarga(3'd2, 16'h0300);
    issue(3'd7, 3'd1, 3'd2, 3'd3, 1);
    wait_idle();
    check("mult_alto_acarreo", Acarreo, 1);
    check("mult_alto_cero", Cero, 1);
    precarga(3'd1, 16'h00FF);
    precarga(3'd2, 16'h0101);
    issue(3'd7, 3'd1, 3'd2, 3'd3, 1);
    wait_idle();
    check("mult_ffff_banco", banco[3], 16'hFFFF);
    check("mult_ffff_acarreo", Acarreo, 0);
    precarga(3'd1, 16'h8001);
    precarga(3'd2, 16'h0011);
    issue(3'd5, 3'd1, 3'd2, 3'd3, 1);
    wait_idle();
    check("shl_1", banco[3], 16'h0002);
    precarga(3'd2, 16'h0010);
    issue(3'd5, 3'd1, 3'd2, 3'd3, 1);
    wait_idle();
    check("shl_0", banco[3], 16'h8001);
    w0 = escrituras;
    issue(3'd7, 3'd1, 3'd2, 3'd0, 18);
    wait_idle();
    repeat (3) @(negedge Reloj);
    check("inicio_sostenido_escrituras", escrituras - w0, 1);
    issue(3'd7, 3'd1, 3'd2, 3'd6, 1);
    repeat (7) @(negedge Reloj);
    sb.delete();
    Reiniciar = 1'b1;
    @(negedge Reloj);
    Reiniciar = 1'b0;
    check_ceros("reset_mult");
    w0 = escrituras;
    repeat (25) @(negedge Reloj);
    check("reset_mult_sin_escritura", escrituras - w0, 0);
    issue(3'd2, 3'd1, 3'd2, 3'd6, 1);
    wait_idle();
    precarga(3'd5, 16'h0002);
    issue(3'd0, 3'd5, 3'd5, 3'd5, 1);
    wait_idle();
    check("autodestino_banco", banco[5], 16'h0004);
    issue(3'd3, 3'd5, 3'd5, 3'd6, 1);
    wait_idle();
    check("autodestino_lectura", banco[6], 16'h0004);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(3))
          0: v = 16'h0000;
          1: v = 16'hFFFF;
          default: v = 16'($urandom);
        endcase
        precarga(3'($urandom_range(7)), v);
      end
      issue(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 1);
      wait_idle();
    end
    for (int i = 0; i < 8; i++) check("banco_final", banco[i], ref_regs[i]);
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
